// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the MEM/WB
// writeback path and the mul/div result channel. WB always wins; mul/div
// results wait in a small FIFO and drain into idle port cycles. A starvation
// FSM raises o_stall_req when the FIFO has been blocked for too long.
// Optional feature macro: WB_ARB_STATS_EN adds o_defer_cnt (deferred-drain
// cycle counter).
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wb_we,
    input  logic [4:0]  i_wb_waddr,
    input  logic [31:0] i_wb_wdata,
    input  logic        i_md_valid,
    input  logic [4:0]  i_md_waddr,
    input  logic [31:0] i_md_wdata,
    output logic        o_md_ready,
    output logic        o_rf_we,
    output logic [4:0]  o_rf_waddr,
    output logic [31:0] o_rf_wdata,
    output logic        o_stall_req
`ifdef WB_ARB_STATS_EN
    ,
    output logic [15:0] o_defer_cnt
`endif
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [3:0]  LIM      = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_STARVE} state_t;

    logic [DEPTH-1:0] r_vld;
    logic [4:0]       r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_cnt;
    logic [3:0]       r_starve;
    logic [3:0]       w_starve_nxt;
    state_t           r_state, w_state_nxt;
    logic             r_stall;

    logic w_full, w_empty, w_push, w_pop, w_kill_en;

    assign w_full     = (r_cnt == FULL_CNT);
    assign w_empty    = (r_cnt == '0);
    assign o_md_ready = !w_full && i_rst_n;
    assign w_push     = i_md_valid && o_md_ready;
    assign w_pop      = !i_wb_we && !w_empty;
    // A WB write is younger than anything queued for the same register.
    assign w_kill_en  = i_wb_we && (i_wb_waddr != 5'd0);

    // FIFO storage, pointers and count; a same-cycle push overrides a kill.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_vld  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_kill_en && (r_addr[i] == i_wb_waddr))
                    r_vld[i] <= 1'b0;
            end
            if (w_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + 1'b1;
            end
            if (w_push) begin
                r_vld[r_wptr]  <= 1'b1;
                r_addr[r_wptr] <= i_md_waddr;
                r_data[r_wptr] <= i_md_wdata;
                r_wptr         <= r_wptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Registered write port: WB first, then FIFO head; $0 and killed entries write nothing.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_rf_we    <= 1'b0;
            o_rf_waddr <= '0;
            o_rf_wdata <= '0;
        end else if (i_wb_we) begin
            o_rf_we    <= (i_wb_waddr != 5'd0);
            o_rf_waddr <= i_wb_waddr;
            o_rf_wdata <= i_wb_wdata;
        end else if (w_pop) begin
            o_rf_we    <= r_vld[r_rptr] && (r_addr[r_rptr] != 5'd0);
            o_rf_waddr <= r_addr[r_rptr];
            o_rf_wdata <= r_data[r_rptr];
        end else begin
            o_rf_we    <= 1'b0;
        end
    end

    // Next state and starve counter from the registered count and counter.
    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve;
        if (w_empty || w_pop)
            w_starve_nxt = '0;
        else if (i_wb_we && (r_starve != LIM))
            w_starve_nxt = r_starve + 1'b1;
        unique case (r_state)
            S_IDLE:   if (!w_empty) w_state_nxt = S_PEND;
            S_PEND: begin
                if (w_empty)              w_state_nxt = S_IDLE;
                else if (r_starve == LIM) w_state_nxt = S_STARVE;
            end
            S_STARVE: if (w_empty) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // State, starve counter and registered stall request.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
            r_stall  <= (w_state_nxt == S_STARVE);
        end
    end

    assign o_stall_req = r_stall;

`ifdef WB_ARB_STATS_EN
    logic [15:0] r_defer;

    // Count cycles where a queued result was held back by a WB write.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_defer <= '0;
        else if (!w_empty && i_wb_we && (r_defer != 16'hFFFF))
            r_defer <= r_defer + 1'b1;
    end

    assign o_defer_cnt = r_defer;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table plus randomized traffic
// checked against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk;
    logic        rst_n, wb_we, md_valid;
    logic [4:0]  wb_waddr, md_waddr;
    logic [31:0] wb_wdata, md_wdata;
    logic        md_ready, rf_we, stall_req;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef WB_ARB_STATS_EN
    logic [15:0] defer_cnt;
`endif

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wb_we(wb_we), .i_wb_waddr(wb_waddr), .i_wb_wdata(wb_wdata),
        .i_md_valid(md_valid), .i_md_waddr(md_waddr), .i_md_wdata(md_wdata),
        .o_md_ready(md_ready), .o_rf_we(rf_we), .o_rf_waddr(rf_waddr),
        .o_rf_wdata(rf_wdata), .o_stall_req(stall_req)
`ifdef WB_ARB_STATS_EN
        , .o_defer_cnt(defer_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          v;
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    int          m_ctr;
    bit          m_starving;
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_defer;

    task automatic model_edge();
        int   old_size, old_ctr;
        bit   old_starv, push, pop;
        ent_t h;
        if (!rst_n) begin
            q.delete();
            m_ctr = 0; m_starving = 0; m_we = 0; m_addr = '0; m_data = '0; m_defer = 0;
            return;
        end
        old_size  = q.size();
        old_ctr   = m_ctr;
        old_starv = m_starving;
        push = md_valid && (old_size < DEPTH);
        pop  = !wb_we && (old_size > 0);
        if (wb_we) begin
            m_we = (wb_waddr != 0); m_addr = wb_waddr; m_data = wb_wdata;
        end else if (pop) begin
            h = q[0];
            m_we = h.v && (h.a != 0); m_addr = h.a; m_data = h.d;
        end else begin
            m_we = 0;
        end
        if (wb_we && wb_waddr != 0) begin
            for (int i = 0; i < q.size(); i++) begin
                h = q[i];
                if (h.a == wb_waddr) begin
                    h.v = 0;
                    q[i] = h;
                end
            end
        end
        if (pop) void'(q.pop_front());
        if (push) begin
            h.v = 1; h.a = md_waddr; h.d = md_wdata;
            q.push_back(h);
        end
        if (old_size > 0 && wb_we && m_defer < 16'hFFFF) m_defer++;
        if (old_size == 0 || pop) m_ctr = 0;
        else if (wb_we)           m_ctr = (m_ctr + 1 > LIMIT) ? LIMIT : m_ctr + 1;
        m_starving = old_starv ? (old_size != 0) : (old_ctr == LIMIT);
    endtask

    // One clock: drive inputs, take the edge, update the model, compare.
    task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic mv, input logic [4:0] ma,
                        input logic [31:0] md);
        rst_n = rst; wb_we = we; wb_waddr = wa; wb_wdata = wd;
        md_valid = mv; md_waddr = ma; md_wdata = md;
        @(posedge clk);
        model_edge();
        #1;
        chk("model rf_we", 32'(rf_we), 32'(m_we));
        if (m_we) begin
            chk("model rf_waddr", 32'(rf_waddr), 32'(m_addr));
            chk("model rf_wdata", rf_wdata, m_data);
        end
        chk("model stall_req", 32'(stall_req), 32'(m_starving));
        chk("model md_ready", 32'(md_ready), 32'(rst_n && (q.size() < DEPTH)));
`ifdef WB_ARB_STATS_EN
        chk("model defer_cnt", 32'(defer_cnt), 32'(m_defer));
`endif
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        rst, we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_stall, e_rdy;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic rst, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd,
                       input logic e_stall, input logic e_rdy);
        vec_t v;
        v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.mv = mv; v.ma = ma; v.md = md;
        v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd; v.e_stall = e_stall; v.e_rdy = e_rdy;
        tv.push_back(v);
    endtask

    initial begin
        logic        r_rst, r_we, r_mv;
        logic [4:0]  r_wa, r_ma;
        logic [31:0] r_wd, r_md;
        int          pwb;

        rst_n = 0; wb_we = 0; wb_waddr = 0; wb_wdata = 0;
        md_valid = 0; md_waddr = 0; md_wdata = 0;
        m_ctr = 0; m_starving = 0; m_we = 0; m_addr = 0; m_data = 0; m_defer = 0;

        //   rst we wa  wd             mv ma  md            e_we e_wa e_wd          stall rdy
        add(0, 0, 0,  0,             0, 0,  0,            0, 0,  0,             0, 0); // reset
        add(1, 1, 5,  32'hDEAD_BEEF, 0, 0,  0,            1, 5,  32'hDEAD_BEEF, 0, 1); // WB only
        add(1, 0, 0,  0,             1, 9,  32'h1234,     0, 0,  0,             0, 1); // push
        add(1, 0, 0,  0,             0, 0,  0,            1, 9,  32'h1234,      0, 1); // idle drain
        add(1, 0, 0,  0,             0, 0,  0,            0, 0,  0,             0, 1);
        add(1, 1, 1,  32'h11,        1, 10, 32'hA0,       1, 1,  32'h11,        0, 1); // full/starve
        add(1, 1, 2,  32'h22,        1, 11, 32'hB0,       1, 2,  32'h22,        0, 0);
        add(1, 1, 3,  32'h33,        1, 12, 32'hC0,       1, 3,  32'h33,        0, 0); // rejected
        add(1, 1, 4,  32'h44,        0, 0,  0,            1, 4,  32'h44,        0, 0);
        add(1, 1, 5,  32'h55,        0, 0,  0,            1, 5,  32'h55,        0, 0); // ctr=4
        add(1, 1, 6,  32'h66,        0, 0,  0,            1, 6,  32'h66,        1, 0); // stall
        add(1, 0, 0,  0,             0, 0,  0,            1, 10, 32'hA0,        1, 1);
        add(1, 0, 0,  0,             0, 0,  0,            1, 11, 32'hB0,        1, 1);
        add(1, 0, 0,  0,             0, 0,  0,            0, 0,  0,             0, 1); // stall drop
        add(1, 1, 3,  32'h33,        1, 7,  32'h5555,     1, 3,  32'h33,        0, 1); // kill
        add(1, 1, 7,  32'hAAAA,      0, 0,  0,            1, 7,  32'hAAAA,      0, 1);
        add(1, 0, 0,  0,             0, 0,  0,            0, 0,  0,             0, 1); // killed pop
        add(1, 0, 0,  0,             0, 0,  0,            0, 0,  0,             0, 1);
        add(1, 1, 0,  32'hFFFF,      1, 0,  32'h1,        0, 0,  0,             0, 1); // $0
        add(1, 0, 0,  0,             0, 0,  0,            0, 0,  0,             0, 1);
        add(1, 0, 0,  0,             0, 0,  0,            0, 0,  0,             0, 1);
        add(1, 1, 1,  32'h1,         1, 20, 32'h20,       1, 1,  32'h1,         0, 1); // reset mid-op
        add(1, 1, 2,  32'h2,         1, 21, 32'h21,       1, 2,  32'h2,         0, 0);
        add(0, 1, 3,  32'h3,         1, 22, 32'h22,       0, 0,  0,             0, 0);
        add(1, 0, 0,  0,             0, 0,  0,            0, 0,  0,             0, 1);
        add(1, 0, 0,  0,             0, 0,  0,            0, 0,  0,             0, 1);
        add(1, 1, 8,  32'h8,         1, 8,  32'h88,       1, 8,  32'h8,         0, 1); // push+kill same X
        add(1, 0, 0,  0,             0, 0,  0,            1, 8,  32'h88,        0, 1);
        add(1, 0, 0,  0,             1, 12, 32'hC,        0, 0,  0,             0, 1); // push+pop net 0
        add(1, 0, 0,  0,             1, 13, 32'hD,        1, 12, 32'hC,         0, 1);
        add(1, 0, 0,  0,             0, 0,  0,            1, 13, 32'hD,         0, 1);
        add(1, 0, 0,  0,             0, 0,  0,            0, 0,  0,             0, 1);

        for (int k = 0; k < tv.size(); k++) begin
            step(tv[k].rst, tv[k].we, tv[k].wa, tv[k].wd, tv[k].mv, tv[k].ma, tv[k].md);
            chk($sformatf("vec%0d rf_we", k), 32'(rf_we), 32'(tv[k].e_we));
            if (tv[k].e_we) begin
                chk($sformatf("vec%0d rf_waddr", k), 32'(rf_waddr), 32'(tv[k].e_wa));
                chk($sformatf("vec%0d rf_wdata", k), rf_wdata, tv[k].e_wd);
            end
            chk($sformatf("vec%0d stall_req", k), 32'(stall_req), 32'(tv[k].e_stall));
            chk($sformatf("vec%0d md_ready", k), 32'(md_ready), 32'(tv[k].e_rdy));
        end

        // Randomized traffic; WB-heavy phases force starvation and full FIFO.
        for (int blk = 0; blk < 10; blk++) begin
            pwb = (blk % 3 == 0) ? 90 : 50;
            for (int c = 0; c < 200; c++) begin
                r_rst = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
                r_we  = ($urandom_range(99) < pwb);
                r_wa  = 5'($urandom_range(7));
                r_wd  = $urandom;
                r_mv  = ($urandom_range(99) < 50);
                r_ma  = 5'($urandom_range(7));
                r_md  = $urandom;
                step(r_rst, r_we, r_wa, r_wd, r_mv, r_ma, r_md);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
